// File: rtl/deserializer_if.sv
// deserializer_if: serial-in / FIFO-write bundle for the UART receiver.
// master is the receiver side, slave is the line driver plus FIFO side.
interface deserializer_if;
  logic       rcv_bit;
  logic       fifo_full;
  logic       wr_fifo;
  logic [7:0] wr_fifo_data;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  modport master (
    input  rcv_bit,
    input  fifo_full,
    output wr_fifo,
    output wr_fifo_data,
    output frame_err,
    output overrun_err,
    output rx_busy
  );

  modport slave (
    output rcv_bit,
    output fifo_full,
    input  wr_fifo,
    input  wr_fifo_data,
    input  frame_err,
    input  overrun_err,
    input  rx_busy
  );
endinterface

// File: rtl/deserializer.sv
// deserializer: UART receiver, 8N1, LSB first, mid-bit sampling.
// Pushes each good byte to the receive FIFO; flags framing/overrun.
module deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  deserializer_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;
  logic [1:0]    sync_q, sync_d;
  logic          rx_s;

  // two-flop synchronizer; idle-high reset avoids a false start
  always_comb begin
    sync_d = {sync_q[0], bus.rcv_bit};
  end

  assign rx_s = sync_q[1];

  // synchronizer, FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  // next-state, bit timing and stop-bit decision
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // a start that is gone by mid-bit is a glitch
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          unique case (1'b1)
            !rx_s: begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
            bus.fifo_full: begin
              oerr_d  = 1'b1;
              state_d = S_IDLE;
            end
            default: begin
              wr_d    = 1'b1;
              data_d  = shift_q;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        // hold here while the line stays low so a break flags once
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.wr_fifo      = wr_q;
  assign bus.wr_fifo_data = data_q;
  assign bus.frame_err    = ferr_q;
  assign bus.overrun_err  = oerr_q;
  assign bus.rx_busy      = (state_q != S_IDLE);

endmodule

// File: doc/deserializer.md
# deserializer

UART receive-side deserializer: watches the asynchronous serial input, detects a start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and pushes the assembled byte into the receive FIFO with a one-cycle write strobe. It is the receive counterpart of the transmit serializer and uses the same frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), line idle high. Framing errors and FIFO overruns are flagged with single-cycle pulses.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4. Counter width is $clog2(CLKS_PER_BIT).
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rcv_bit  input  1  serial line, asynchronous to clk; idle high
- fifo_full  input  1  receive FIFO full; sampled only at the stop-bit sample point
- wr_fifo  output  1  one-cycle write strobe to the receive FIFO
- wr_fifo_data  output  8  received byte; valid when wr_fifo=1, held until the next write
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun_err  output  1  one-cycle pulse: good frame received while fifo_full=1; byte dropped
- rx_busy  output  1  high in every state except IDLE

## Operation
- Input synchronizer: two flops on rcv_bit, both reset to 1. All decisions use the synchronized value `rx_s`.
- The FSM has five states. Each state other than IDLE and BREAK uses a bit counter `cnt` that is cleared on state entry.
- IDLE: when rx_s=0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - When cnt = CLKS_PER_BIT/2-1, sample rx_s.
  - If rx_s=0: go to DATA with cnt=0 and bit_idx=0.
  - If rx_s=1: treat the start as a glitch and return to IDLE. No flag is raised.
- DATA:
  - When cnt = CLKS_PER_BIT-1, sample rx_s into shift register bit position bit_idx, clear cnt, and increment bit_idx.
  - After bit_idx 7 is captured, go to STOP with cnt=0.
- STOP: when cnt = CLKS_PER_BIT-1, sample rx_s, then:
  - rx_s=1 and fifo_full=0: drive wr_fifo=1 and load wr_fifo_data with the shift register. Go to IDLE.
  - rx_s=1 and fifo_full=1: drive overrun_err=1. No write; wr_fifo_data is unchanged. Go to IDLE.
  - rx_s=0: drive frame_err=1. No write. Go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no spurious frames.
- wr_fifo, frame_err and overrun_err are registered. Each is high for exactly one cycle and they are mutually exclusive.
- fifo_full is never sampled outside the stop sample point. The block has no backpressure; it never stalls the line.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state IDLE, cnt=0, bit_idx=0, shift register 0, sync flops 1.
- Output reset values: wr_fifo=0, wr_fifo_data=8'h00, frame_err=0, overrun_err=0, rx_busy=0.
- Reset mid-frame aborts the frame with no strobe or flag. Reception restarts on the next falling edge after rst_n deasserts.
- Edge-detect latency: rcv_bit falling at clock edge E is first seen by IDLE at E+2 (synchronizer). START is entered at E+3; call this cycle T.
- Sample points:
  - start bit at T + CLKS_PER_BIT/2;
  - data bit k (k=0..7) at T + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at T + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The wr_fifo, frame_err or overrun_err pulse is visible in the cycle after the stop sample edge. rx_busy falls in the same cycle.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is detected. Roughly half a bit time of slack absorbs the 2-cycle synchronizer delay.
- Tolerance: accepts sender/receiver clock mismatch up to about ±4% at CLKS_PER_BIT=16.

## Test plan
- Byte 0xA5, CLKS_PER_BIT=16, clean frame (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one wr_fifo pulse with wr_fifo_data=8'hA5, 3+8+144 cycles after the line's falling edge. No error flags; rx_busy low afterwards.
- 4-cycle low glitch on an idle line -> no wr_fifo and no flags. rx_busy is high for about 8 cycles, then the block returns to IDLE.
- Frame 0x3C with stop bit 0, line then held low 40 cycles -> one frame_err pulse and no wr_fifo. A following clean 0x3C frame is then written with data 8'h3C.
- fifo_full=1 through a clean 0x55 frame -> one overrun_err pulse, no wr_fifo, wr_fifo_data keeps its previous value. Deassert fifo_full, send 0x66 -> written.
- Back-to-back 0x00 then 0xFF with one stop bit each -> two wr_fifo pulses 160 cycles apart, data 8'h00 then 8'hFF.
- Assert rst_n=0 during data bit 4 of a frame -> all outputs 0 immediately. Release, send 0x81 -> single write of 8'h81.
